glitch_filter: RTL and testbench
================================

GLITCH_FILTER -- requirements
Module: glitch_filter

Interface
REQ-001 The block SHALL have parameter SYNC_STAGES, default 2, number of synchroniser flops on i_in; legal range 2..4.
REQ-002 The block SHALL have parameter FILTER_CNT, default 4, consecutive stable synchronised cycles required before o_out changes; legal range 1..255.
REQ-003 The block SHALL have parameter RESET_VAL, default 1'b0, reset level of the synchroniser chain and o_out.
REQ-004 The block SHALL have port i_clk, input, 1, sole clock; all flops on rising edge.
REQ-005 The block SHALL have port i_rst, input, 1: one clock; reset is synchronous and active-high.
REQ-006 The block SHALL have port i_in, input, 1, asynchronous raw level (e.g. buffered pad or delay-cell output).
REQ-007 The block SHALL have port o_out, output, 1, filtered, synchronised level.
REQ-008 The block SHALL have port o_rise, output, 1, one-cycle pulse on o_out 0->1.
REQ-009 The block SHALL have port o_fall, output, 1, one-cycle pulse on o_out 1->0.

Function
REQ-010 i_in SHALL pass through a SYNC_STAGES-deep flop chain; the last stage is the sample s; no logic between chain stages.
REQ-011 A counter cnt of width clog2(FILTER_CNT+1), minimum 1 bit, SHALL track consecutive cycles with s != o_out.
REQ-012 If s == o_out on an edge, cnt SHALL load 0 and o_out SHALL hold.
REQ-013 If s != o_out and cnt < FILTER_CNT-1, cnt SHALL increment by 1 and o_out SHALL hold.
REQ-014 If s != o_out and cnt == FILTER_CNT-1, o_out SHALL load s and cnt SHALL load 0 on the same edge.
REQ-015 cnt SHALL never exceed FILTER_CNT-1 and SHALL NOT wrap.
REQ-016 Latency: a level on i_in stable from sampling edge k SHALL appear on o_out after edge k+SYNC_STAGES+FILTER_CNT-1, i.e. SYNC_STAGES+FILTER_CNT edges.
REQ-017 Pulses at s shorter than FILTER_CNT cycles SHALL be rejected with no o_out change and no o_rise/o_fall.
REQ-018 A mismatch interrupted by one matching cycle SHALL restart counting from 0.
REQ-019 With FILTER_CNT == 1, o_out SHALL follow s with one cycle of delay and no filtering.
REQ-020 o_rise and o_fall SHALL be registered, asserted for exactly one cycle, coincident with the cycle o_out first shows its new value.
REQ-021 o_rise and o_fall SHALL never be high in the same cycle.
REQ-022 All outputs SHALL be driven directly from flops.

Reset
REQ-023 While i_rst is high at a rising i_clk edge, all synchroniser flops and o_out SHALL load RESET_VAL, and cnt, o_rise and o_fall SHALL load 0.
REQ-024 Reset asserted mid-count SHALL discard partial count; no edge pulse SHALL be generated by reset itself or by its release.
REQ-025 After i_rst deasserts, filtering SHALL resume on the next edge using the RESET_VAL state.

Configuration
REQ-026 Macro GLITCH_FILTER_EDGE_EN: when defined, the o_rise/o_fall logic of REQ-020/REQ-021 SHALL be compiled in.
REQ-027 When GLITCH_FILTER_EDGE_EN is undefined, o_rise and o_fall SHALL still exist as ports, tied constant 0, with no edge flops.
REQ-028 GLITCH_FILTER_EDGE_EN SHALL NOT alter o_out behaviour or timing.

Verification (SYNC_STAGES=2, FILTER_CNT=4, RESET_VAL=0, GLITCH_FILTER_EDGE_EN defined unless noted)
REQ-029 Step: i_in 0->1 held before edge 10 -> o_out=1 visible after edge 15; o_rise=1 for exactly that cycle; o_fall=0 throughout.
REQ-030 Glitch rejection: i_in high for 3 cycles then low -> o_out stays 0; o_rise and o_fall never asserted.
REQ-031 Count restart: i_in high 3 cycles, low 1 cycle, high 4+ cycles -> o_out rises only 4 cycles after the second high run reaches s.
REQ-032 Reset mid-count: i_in high, i_rst pulsed 1 cycle when cnt=2 -> o_out=0, cnt=0, no pulse; o_out rises SYNC_STAGES+FILTER_CNT edges after release.
REQ-033 FILTER_CNT=1: i_in toggles every 3 cycles -> o_out reproduces the toggles delayed by 3 edges.
REQ-034 GLITCH_FILTER_EDGE_EN undefined: stimulus as REQ-029 -> o_out identical; o_rise=o_fall=0 at all times.

Source files
------------

// File: rtl/glitch_filter.sv
// rtl/glitch_filter.sv - debounce/glitch filter for an asynchronous level input
//
// Purpose:
//   Synchronises the raw level i_in through a SYNC_STAGES-deep flop chain and
//   lets the filtered output o_out follow the synchronised sample only after
//   it has differed from o_out for FILTER_CNT consecutive cycles.
//
// Parameters:
//   SYNC_STAGES  synchroniser depth, 2..4
//   FILTER_CNT   consecutive mismatching cycles needed to change o_out, 1..255
//   RESET_VAL    reset level of the synchroniser chain and o_out
//
// Ports:
//   i_clk   in   sole clock, rising edge
//   i_rst   in   synchronous active-high reset
//   i_in    in   asynchronous raw level
//   o_out   out  filtered, synchronised level (registered)
//   o_rise  out  one-cycle pulse coincident with o_out going 0->1
//   o_fall  out  one-cycle pulse coincident with o_out going 1->0
//
// Configuration macro:
//   GLITCH_FILTER_EDGE_EN  when defined, o_rise/o_fall are generated from
//                          flops; otherwise both are tied to 0.

module glitch_filter #(
  parameter int   SYNC_STAGES = 2,
  parameter int   FILTER_CNT  = 4,
  parameter logic RESET_VAL   = 1'b0
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_in,
  output logic o_out,
  output logic o_rise,
  output logic o_fall
);

  localparam int CNT_W = ($clog2(FILTER_CNT + 1) < 1) ? 1 : $clog2(FILTER_CNT + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(FILTER_CNT - 1);

  logic [SYNC_STAGES-1:0] sync;
  logic [CNT_W-1:0]       cnt;
  logic                   s;
  logic                   mismatch;
  logic                   accept;

  // Last chain stage is the only value the filter ever looks at.
  assign s        = sync[SYNC_STAGES-1];
  assign mismatch = (s != o_out);
  // Mismatch has now persisted FILTER_CNT cycles including this one.
  assign accept   = mismatch && (cnt == CNT_MAX);

  // Pure shift chain: nothing between stages so metastability can settle.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      sync <= {SYNC_STAGES{RESET_VAL}};
    end else begin
      sync <= {sync[SYNC_STAGES-2:0], i_in};
    end
  end

  // Counter saturates at CNT_MAX by construction: reaching it with a
  // continued mismatch updates o_out, which clears the mismatch.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      cnt   <= '0;
      o_out <= RESET_VAL;
    end else if (!mismatch) begin
      cnt <= '0;
    end else if (accept) begin
      cnt   <= '0;
      o_out <= s;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

`ifdef GLITCH_FILTER_EDGE_EN
  logic rise_q;
  logic fall_q;

  // Registered alongside o_out so the pulse lands in the cycle o_out
  // first shows its new value; accept implies s != o_out, so only one fires.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      rise_q <= 1'b0;
      fall_q <= 1'b0;
    end else begin
      rise_q <= accept &&  s;
      fall_q <= accept && !s;
    end
  end

  assign o_rise = rise_q;
  assign o_fall = fall_q;
`else
  assign o_rise = 1'b0;
  assign o_fall = 1'b0;
`endif

endmodule

// File: tb/tb_glitch_filter.sv
// tb/tb_glitch_filter.sv - self-checking bench for glitch_filter (FILTER_CNT 4 and 1)

module tb_glitch_filter;

`ifdef GLITCH_FILTER_EDGE_EN
  localparam bit EDGE_EN = 1'b1;
`else
  localparam bit EDGE_EN = 1'b0;
`endif

  localparam int MAXE = 2048;
  localparam int S_P [2] = '{2, 2};
  localparam int F_P [2] = '{4, 1};

  logic i_clk = 1'b0;
  logic i_rst = 1'b1;
  logic i_in  = 1'b0;
  logic out0, rise0, fall0;
  logic out1, rise1, fall1;

  int checks = 0;
  int errors = 0;

  always #5 i_clk = ~i_clk;

  glitch_filter #(.SYNC_STAGES(2), .FILTER_CNT(4), .RESET_VAL(1'b0)) dut0 (
    .i_clk (i_clk),
    .i_rst (i_rst),
    .i_in  (i_in),
    .o_out (out0),
    .o_rise(rise0),
    .o_fall(fall0)
  );

  glitch_filter #(.SYNC_STAGES(2), .FILTER_CNT(1), .RESET_VAL(1'b0)) dut1 (
    .i_clk (i_clk),
    .i_rst (i_rst),
    .i_in  (i_in),
    .o_out (out1),
    .o_rise(rise1),
    .o_fall(fall1)
  );

  task automatic chk(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at t=%0t: actual=%0b expected=%0b", name, $time, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Records every sampled input and reset; the synchronised sample after
  // edge m is the input sampled SYNC_STAGES-1 edges earlier, or the reset
  // level if a reset hit any edge in between. o_out changes at edge n iff the
  // FILTER_CNT samples seen at edges n-F..n-1 all agree, differ from o_out,
  // and no reset happened after edge n-F.
  logic in_h  [MAXE];
  logic rst_h [MAXE];
  int   n = 0;
  logic e_out  [2] = '{1'b0, 1'b0};
  logic e_rise [2] = '{1'b0, 1'b0};
  logic e_fall [2] = '{1'b0, 1'b0};
  int   last_rst [2] = '{0, 0};

  function automatic logic s_at(input int m, input int ss);
    if (m < 0) return 1'b0;
    for (int k = m - ss + 1; k <= m; k++) begin
      if (k < 0 || rst_h[k]) return 1'b0;
    end
    return in_h[m - ss + 1];
  endfunction

  always @(posedge i_clk) begin
    in_h[n]  = i_in;
    rst_h[n] = i_rst;
    for (int i = 0; i < 2; i++) begin
      e_rise[i] = 1'b0;
      e_fall[i] = 1'b0;
      if (i_rst) begin
        e_out[i]    = 1'b0;
        last_rst[i] = n;
      end else if (n - F_P[i] >= last_rst[i]) begin
        logic v;
        logic same;
        v    = s_at(n - F_P[i], S_P[i]);
        same = 1'b1;
        for (int m = n - F_P[i]; m < n; m++) begin
          if (s_at(m, S_P[i]) != v) same = 1'b0;
        end
        if (same && v != e_out[i]) begin
          e_out[i]  = v;
          e_rise[i] = EDGE_EN &&  v;
          e_fall[i] = EDGE_EN && !v;
        end
      end
    end
    n++;
  end

  // Single compare process: every cycle, both instances against the model.
  always @(negedge i_clk) begin
    if (n > 0) begin
      chk("m0_out",  out0,  e_out[0]);
      chk("m0_rise", rise0, e_rise[0]);
      chk("m0_fall", fall0, e_fall[0]);
      chk("m1_out",  out1,  e_out[1]);
      chk("m1_rise", rise1, e_rise[1]);
      chk("m1_fall", fall1, e_fall[1]);
    end
  end

  task automatic tick();
    @(posedge i_clk);
    @(negedge i_clk);
  endtask

  task automatic hold(input logic v, input int cycles);
    i_in = v;
    for (int c = 0; c < cycles; c++) tick();
  endtask

  // ---------------- directed stimulus with literal expectations ----------------
  initial begin
    logic drv [64];

    // reset state
    i_rst = 1'b1;
    i_in  = 1'b0;
    for (int c = 0; c < 3; c++) tick();
    chk("rst_out0", out0, 1'b0);
    chk("rst_rise0", rise0, 1'b0);
    chk("rst_fall0", fall0, 1'b0);
    chk("rst_out1", out1, 1'b0);
    i_rst = 1'b0;
    hold(1'b0, 4);

    // step 0->1: visible after the 6th edge (SYNC_STAGES+FILTER_CNT)
    i_in = 1'b1;
    for (int c = 1; c <= 6; c++) begin
      tick();
      chk("step_out0", out0, c == 6);
      chk("step_rise0", rise0, EDGE_EN && c == 6);
      chk("step_fall0", fall0, 1'b0);
      chk("step_out1", out1, c >= 3);
    end
    tick();
    chk("step_rise0_once", rise0, 1'b0);
    chk("step_out0_hold", out0, 1'b1);
    hold(1'b1, 3);

    // step 1->0
    i_in = 1'b0;
    for (int c = 1; c <= 6; c++) begin
      tick();
      chk("fall_out0", out0, c < 6);
      chk("fall_fall0", fall0, EDGE_EN && c == 6);
      chk("fall_rise0", rise0, 1'b0);
    end
    hold(1'b0, 6);

    // glitch of 3 cycles is rejected
    i_in = 1'b1;
    for (int c = 1; c <= 11; c++) begin
      if (c == 4) i_in = 1'b0;
      tick();
      chk("glitch_out0", out0, 1'b0);
      chk("glitch_rise0", rise0, 1'b0);
      chk("glitch_fall0", fall0, 1'b0);
    end

    // count restart: 3 high, 1 low, then high
    hold(1'b1, 3);
    hold(1'b0, 1);
    i_in = 1'b1;
    for (int c = 1; c <= 6; c++) begin
      tick();
      chk("restart_out0", out0, c == 6);
      chk("restart_rise0", rise0, EDGE_EN && c == 6);
    end
    hold(1'b1, 2);
    hold(1'b0, 10);

    // reset mid-count (cnt == 2 after the 4th edge)
    hold(1'b1, 4);
    i_rst = 1'b1;
    tick();
    chk("midrst_out0", out0, 1'b0);
    chk("midrst_rise0", rise0, 1'b0);
    chk("midrst_fall0", fall0, 1'b0);
    i_rst = 1'b0;
    for (int c = 1; c <= 6; c++) begin
      tick();
      chk("release_out0", out0, c == 6);
      chk("release_rise0", rise0, EDGE_EN && c == 6);
    end
    hold(1'b1, 2);
    hold(1'b0, 10);

    // FILTER_CNT=1: toggles every 3 cycles reproduced 3 edges later
    for (int c = 0; c < 40; c++) begin
      drv[c] = ((c / 3) % 2 == 1);
      i_in   = drv[c];
      tick();
      chk("toggle_out1", out1, (c >= 2) ? drv[c-2] : 1'b0);
    end
    hold(1'b0, 8);

    // mixed random traffic with occasional reset, model-checked only
    for (int c = 0; c < 300; c++) begin
      i_in  = (($urandom % 4) == 0) ? ~i_in : i_in;
      i_rst = (($urandom % 40) == 0);
      tick();
    end
    i_rst = 1'b0;
    hold(1'b0, 10);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule
